riscv_hzrd_unit: RTL
====================

Name: riscv_hzrd_unit

Overview:
- Hazard and pipeline-control unit for the five-stage RV64 core.
- Drives the stall and flush controls of the FD, DE and EM pipeline registers, and the operand forwarding selects used in execute.
- Tracks multi-cycle mul/div operations with a start/done handshake, a watchdog, and a saturating stall-cycle counter.

Parameters:
- MD_MAX_CYCLES, 72, watchdog limit in cycles for one mul/div operation (≥2).
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- i_riscv_hzrd_clk  in  1  clock
- i_riscv_hzrd_rst  in  1  synchronous active-high reset
- i_riscv_hzrd_rs1addr_d / i_riscv_hzrd_rs2addr_d  in  5 each  source registers in decode
- i_riscv_hzrd_rs1addr_e / i_riscv_hzrd_rs2addr_e  in  5 each  source registers in execute
- i_riscv_hzrd_rdaddr_e  in  5  destination register in execute
- i_riscv_hzrd_memread_e  in  1  load in execute
- i_riscv_hzrd_rdaddr_m, i_riscv_hzrd_regwrite_m  in  5,1  memory-stage writer
- i_riscv_hzrd_rdaddr_w, i_riscv_hzrd_regwrite_w  in  5,1  writeback-stage writer
- i_riscv_hzrd_mdstart_e  in  1  level: mul/div op occupies execute
- i_riscv_hzrd_mddone  in  1  pulse: mul/div result valid this cycle
- i_riscv_hzrd_redirect_e  in  1  taken branch or jump resolved in execute
- i_riscv_hzrd_trap_m  in  1  trap/xRET taken in memory stage
- i_riscv_hzrd_cntclr  in  1  clear stall counter
- o_riscv_hzrd_stall_pc / o_riscv_hzrd_stall_fd / o_riscv_hzrd_stall_de / o_riscv_hzrd_stall_em  out  1 each  1 = hold register
- o_riscv_hzrd_flush_fd / o_riscv_hzrd_flush_de / o_riscv_hzrd_flush_em  out  1 each  1 = clear register to bubble
- o_riscv_hzrd_fwda_sel, o_riscv_hzrd_fwdb_sel  out  2 each  00 regfile, 01 writeback, 10 memory
- o_riscv_hzrd_md_timeout  out  1  one-cycle pulse on watchdog expiry
- o_riscv_hzrd_stallcnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (sync, i_riscv_hzrd_rst=1):
  - FSM→IDLE; cycle counter=0; o_riscv_hzrd_md_timeout=0; o_riscv_hzrd_stallcnt=0.
  - While reset is high: all stalls 0, all flushes 1, both forwarding selects 00.
- Forwarding (combinational, per operand):
  - 10 if regwrite_m && rdaddr_m≠0 && rdaddr_m==rsX_e.
  - Else 01 if regwrite_w && rdaddr_w≠0 && rdaddr_w==rsX_e.
  - Else 00. Memory stage beats writeback on a double match.
- Load-use (combinational): memread_e && rdaddr_e≠0 && (rdaddr_e==rs1addr_d || rdaddr_e==rs2addr_d) → stall_pc=stall_fd=1, flush_de=1.
- Mul/div stall ("mdstall"), FSM states IDLE and MD_BUSY:
  - IDLE:
    - mdstart_e && !mddone → mdstall=1; next MD_BUSY; cnt←1.
    - mdstart_e && mddone → no stall; stay IDLE.
  - MD_BUSY:
    - !mddone && cnt<MD_MAX_CYCLES-1 → mdstall=1; cnt←cnt+1.
    - mddone → mdstall=0 that cycle; next IDLE; cnt←0.
    - !mddone && cnt==MD_MAX_CYCLES-1 → mdstall=0; md_timeout pulses 1 next cycle; next IDLE; cnt←0.
  - mdstall=1 drives stall_pc=stall_fd=stall_de=stall_em=1 and flush_em=1, so EM receives a bubble.
- Priority, highest first:
  1. trap_m: flush_fd=flush_de=flush_em=1, all stalls 0, FSM→IDLE, cnt←0. Overrides an in-flight mul/div (no timeout pulse).
  2. mdstall: redirect_e and load-use are ignored that cycle.
  3. redirect_e: flush_fd=flush_de=1, no stalls. Overrides load-use.
  4. load-use.
  5. Otherwise all stall and flush outputs are 0.
- Stall counter:
  - Increments by 1 in each cycle with stall_fd=1.
  - Saturates at all-ones.
  - cntclr=1 → 0 next cycle; cntclr has priority over increment.
- Latency: every control output except md_timeout and stallcnt is combinational from the current-cycle inputs and FSM state. No output depends combinationally on cntclr.

Decomposition:
- Shared package riscv_hzrd_pkg holds:
  - FSM state encoding (IDLE=1'b0, MD_BUSY=1'b1).
  - Forwarding-select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One natural sub-module: riscv_hzrd_fwd, the combinational forwarding comparator, instantiated per operand.

Test Plan:
- Load-use: memread_e=1, rdaddr_e=5, rs2addr_d=5 → stall_pc=stall_fd=flush_de=1, stall_de=0. Repeat with rdaddr_e=0 → no stall.
- Forwarding: regwrite_m=1, rdaddr_m=7, regwrite_w=1, rdaddr_w=7, rs1addr_e=7 → fwda_sel=10. Drop regwrite_m → 01. Set rdaddr_m=rdaddr_w=0 → 00.
- Mul/div: mdstart_e=1, mddone pulses 34 cycles later → all four stalls high for exactly 34 cycles, 0 in the done cycle, stallcnt=34.
- Watchdog: MD_MAX_CYCLES=8, mdstart_e held, mddone never asserted → stalls high 7 cycles, md_timeout=1 for 1 cycle, FSM IDLE.
- Trap mid mul/div: trap_m=1 on the 3rd busy cycle → flush_fd/de/em=1, stalls 0, no timeout pulse. A later mdstart_e starts a fresh count from 1.
- Redirect vs load-use in the same cycle → flush_fd=flush_de=1, stall_pc=0. Reset asserted mid-MD_BUSY → next cycle IDLE, stallcnt=0, all flushes 1 while reset is held.

Source files
------------

// File: rtl/riscv_hzrd_pkg.sv
// Shared types and constants for the RV64 hazard / pipeline-control unit.
package riscv_hzrd_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 2;

  // Mul/div tracking FSM states
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } md_state_e;

  typedef logic [FWD_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  // Stall/flush controls for the PC and the FD, DE, EM pipeline registers
  typedef struct packed {
    logic stall_pc;
    logic stall_fd;
    logic stall_de;
    logic stall_em;
    logic flush_fd;
    logic flush_de;
    logic flush_em;
  } hzrd_ctrl_t;

  // True when a writer with write enable targets a non-x0 register equal to rs
  function automatic logic reg_hit(input logic              we,
                                   input logic [REG_AW-1:0] rd,
                                   input logic [REG_AW-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/riscv_hzrd_unit_fwd.sv
// Operand forwarding comparator for one execute-stage source register.
module riscv_hzrd_unit_fwd
  import riscv_hzrd_pkg::*;
(
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              regwrite_w_i,
  output fwd_sel_t          sel_o
);

  // Memory stage holds the younger result, so it wins over writeback
  always_comb begin
    sel_o = FWD_RF;
    if (reg_hit(regwrite_m_i, rd_m_i, rs_e_i)) begin
      sel_o = FWD_MEM;
    end else if (reg_hit(regwrite_w_i, rd_w_i, rs_e_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/riscv_hzrd_unit.sv
// Hazard unit: forwarding selects, load-use / mul-div stalls, flushes,
// mul/div watchdog and a saturating stall-cycle counter.
module riscv_hzrd_unit
  import riscv_hzrd_pkg::*;
#(
  parameter int unsigned MD_MAX_CYCLES = 72,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              i_riscv_hzrd_clk,
  input  logic              i_riscv_hzrd_rst,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rs1addr_d,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rs2addr_d,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rs1addr_e,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rs2addr_e,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rdaddr_e,
  input  logic              i_riscv_hzrd_memread_e,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rdaddr_m,
  input  logic              i_riscv_hzrd_regwrite_m,
  input  logic [REG_AW-1:0] i_riscv_hzrd_rdaddr_w,
  input  logic              i_riscv_hzrd_regwrite_w,
  input  logic              i_riscv_hzrd_mdstart_e,
  input  logic              i_riscv_hzrd_mddone,
  input  logic              i_riscv_hzrd_redirect_e,
  input  logic              i_riscv_hzrd_trap_m,
  input  logic              i_riscv_hzrd_cntclr,
  output logic              o_riscv_hzrd_stall_pc,
  output logic              o_riscv_hzrd_stall_fd,
  output logic              o_riscv_hzrd_stall_de,
  output logic              o_riscv_hzrd_stall_em,
  output logic              o_riscv_hzrd_flush_fd,
  output logic              o_riscv_hzrd_flush_de,
  output logic              o_riscv_hzrd_flush_em,
  output logic [FWD_W-1:0]  o_riscv_hzrd_fwda_sel,
  output logic [FWD_W-1:0]  o_riscv_hzrd_fwdb_sel,
  output logic              o_riscv_hzrd_md_timeout,
  output logic [CNT_W-1:0]  o_riscv_hzrd_stallcnt
);

  localparam int unsigned       MD_CNT_W = $clog2(MD_MAX_CYCLES);
  localparam logic [MD_CNT_W-1:0] MD_LAST = MD_CNT_W'(MD_MAX_CYCLES - 1);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  md_expire_c;
  logic                  mdstall_c;
  logic                  load_use_c;
  logic                  md_timeout_q;
  logic [CNT_W-1:0]      stallcnt_q;
  hzrd_ctrl_t            ctrl_c;
  fwd_sel_t              fwda_c, fwdb_c;

  riscv_hzrd_unit_fwd u_fwd_a (
    .rs_e_i       (i_riscv_hzrd_rs1addr_e),
    .rd_m_i       (i_riscv_hzrd_rdaddr_m),
    .regwrite_m_i (i_riscv_hzrd_regwrite_m),
    .rd_w_i       (i_riscv_hzrd_rdaddr_w),
    .regwrite_w_i (i_riscv_hzrd_regwrite_w),
    .sel_o        (fwda_c)
  );

  riscv_hzrd_unit_fwd u_fwd_b (
    .rs_e_i       (i_riscv_hzrd_rs2addr_e),
    .rd_m_i       (i_riscv_hzrd_rdaddr_m),
    .regwrite_m_i (i_riscv_hzrd_regwrite_m),
    .rd_w_i       (i_riscv_hzrd_rdaddr_w),
    .regwrite_w_i (i_riscv_hzrd_regwrite_w),
    .sel_o        (fwdb_c)
  );

  assign load_use_c = i_riscv_hzrd_memread_e && (i_riscv_hzrd_rdaddr_e != '0) &&
                      ((i_riscv_hzrd_rdaddr_e == i_riscv_hzrd_rs1addr_d) ||
                       (i_riscv_hzrd_rdaddr_e == i_riscv_hzrd_rs2addr_d));

  // FSM state, busy-cycle count and registered watchdog pulse
  always_ff @(posedge i_riscv_hzrd_clk) begin
    if (i_riscv_hzrd_rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      md_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      md_timeout_q <= md_expire_c;
    end
  end

  // Next state: a trap abandons any in-flight mul/div without a timeout
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    md_expire_c = 1'b0;
    if (i_riscv_hzrd_trap_m) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_riscv_hzrd_mdstart_e && !i_riscv_hzrd_mddone) begin
            state_d = ST_MD_BUSY;
            cnt_d   = MD_CNT_W'(1);
          end
        end
        ST_MD_BUSY: begin
          if (i_riscv_hzrd_mddone) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q < MD_LAST) begin
            cnt_d = cnt_q + MD_CNT_W'(1);
          end else begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            md_expire_c = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM output plus prioritised stall/flush resolution
  always_comb begin
    mdstall_c = 1'b0;
    ctrl_c    = '0;
    case (state_q)
      ST_IDLE:    mdstall_c = i_riscv_hzrd_mdstart_e && !i_riscv_hzrd_mddone;
      ST_MD_BUSY: mdstall_c = !i_riscv_hzrd_mddone && (cnt_q < MD_LAST);
      default:    mdstall_c = 1'b0;
    endcase
    if (i_riscv_hzrd_rst || i_riscv_hzrd_trap_m) begin
      ctrl_c.flush_fd = 1'b1;
      ctrl_c.flush_de = 1'b1;
      ctrl_c.flush_em = 1'b1;
    end else if (mdstall_c) begin
      ctrl_c.stall_pc = 1'b1;
      ctrl_c.stall_fd = 1'b1;
      ctrl_c.stall_de = 1'b1;
      ctrl_c.stall_em = 1'b1;
      ctrl_c.flush_em = 1'b1;
    end else if (i_riscv_hzrd_redirect_e) begin
      ctrl_c.flush_fd = 1'b1;
      ctrl_c.flush_de = 1'b1;
    end else if (load_use_c) begin
      ctrl_c.stall_pc = 1'b1;
      ctrl_c.stall_fd = 1'b1;
      ctrl_c.flush_de = 1'b1;
    end
  end

  // Saturating count of cycles with the FD register held
  always_ff @(posedge i_riscv_hzrd_clk) begin
    if (i_riscv_hzrd_rst || i_riscv_hzrd_cntclr) begin
      stallcnt_q <= '0;
    end else if (ctrl_c.stall_fd && (stallcnt_q != {CNT_W{1'b1}})) begin
      stallcnt_q <= stallcnt_q + CNT_W'(1);
    end
  end

  assign o_riscv_hzrd_stall_pc   = ctrl_c.stall_pc;
  assign o_riscv_hzrd_stall_fd   = ctrl_c.stall_fd;
  assign o_riscv_hzrd_stall_de   = ctrl_c.stall_de;
  assign o_riscv_hzrd_stall_em   = ctrl_c.stall_em;
  assign o_riscv_hzrd_flush_fd   = ctrl_c.flush_fd;
  assign o_riscv_hzrd_flush_de   = ctrl_c.flush_de;
  assign o_riscv_hzrd_flush_em   = ctrl_c.flush_em;
  assign o_riscv_hzrd_fwda_sel   = i_riscv_hzrd_rst ? FWD_RF : fwda_c;
  assign o_riscv_hzrd_fwdb_sel   = i_riscv_hzrd_rst ? FWD_RF : fwdb_c;
  assign o_riscv_hzrd_md_timeout = md_timeout_q;
  assign o_riscv_hzrd_stallcnt   = stallcnt_q;

endmodule
